sequence_scan_controller: RTL and testbench

SEQUENCE_SCAN_CONTROLLER -- requirements
Module: sequence_scan_controller

---
 rtl/sequence_scan_controller.sv | 115 +++++++++++
 tb/tb_sequence_scan_controller.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_scan_controller.sv
// sequence_scan_controller
// Streams a captured word MSB-first into an external sequence detector and
// gathers match statistics: whether anything matched, how many match cycles
// were seen (saturating) and the bit index of the first match.
//
// Detector handshake: det_x is valid in every SHIFT cycle, and det_y is
// sampled on the same rising edge that advances the shift register. The
// detector is expected to be combinational (Mealy) from det_x to det_y.
// det_reset is high for the single CLEAR cycle and whenever reset is high.
`timescale 1ns/1ps

module sequence_scan_controller #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic             det_y,
    output logic             det_x,
    output logic             det_reset,
    output logic             busy,
    output logic             done,
    output logic             hit,
    output logic [CNT_W-1:0] match_count,
    output logic [CNT_W-1:0] first_pos,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CNT_W-1:0] bit_cnt;
    logic             det_reset_q;

    // Reset must clear the detector even before the first clock edge.
    assign det_reset = reset | det_reset_q;
    assign state_dbg = state;

    // Scan sequencer with registered detector drive, status and results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            sreg        <= '0;
            bit_cnt     <= '0;
            det_reset_q <= 1'b0;
            det_x       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hit         <= 1'b0;
            match_count <= '0;
            first_pos   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sreg        <= data_in;
                        bit_cnt     <= '0;
                        hit         <= 1'b0;
                        match_count <= '0;
                        first_pos   <= '0;
                        det_reset_q <= 1'b1;
                        busy        <= 1'b1;
                        state       <= CLEAR;
                    end
                end
                CLEAR: begin
                    // det_x is registered, so preload the first bit here.
                    det_reset_q <= 1'b0;
                    det_x       <= sreg[WIDTH-1];
                    state       <= SHIFT;
                end
                SHIFT: begin
                    if (det_y) begin
                        if (match_count != {CNT_W{1'b1}})
                            match_count <= match_count + CNT_W'(1);
                        if (!hit) begin
                            hit       <= 1'b1;
                            first_pos <= bit_cnt;
                        end
                    end
                    sreg <= sreg << 1;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt <= '0;
                        det_x   <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        // Next MSB after this cycle's shift.
                        det_x   <= sreg[WIDTH-2];
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequence_scan_controller.sv
// Testbench for sequence_scan_controller: a 1011 overlapping detector on the
// main instance, plus a 4-bit / 2-bit-count instance whose det_y is tied high.
`timescale 1ns/1ps

module tb_sequence_scan_controller;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start;
    logic [15:0] data_in;
    logic        det_y, det_x, det_reset, busy, done, hit;
    logic [4:0]  match_count, first_pos;
    logic [1:0]  state_dbg;

    logic        start2;
    logic [3:0]  data2;
    logic        det_x2, det_reset2, busy2, done2, hit2;
    logic [1:0]  mc2, fp2, sd2;

    sequence_scan_controller #(.WIDTH(16), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .data_in(data_in),
        .det_y(det_y), .det_x(det_x), .det_reset(det_reset), .busy(busy),
        .done(done), .hit(hit), .match_count(match_count),
        .first_pos(first_pos), .state_dbg(state_dbg)
    );

    sequence_scan_controller #(.WIDTH(4), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .start(start2), .data_in(data2),
        .det_y(1'b1), .det_x(det_x2), .det_reset(det_reset2), .busy(busy2),
        .done(done2), .hit(hit2), .match_count(mc2),
        .first_pos(fp2), .state_dbg(sd2)
    );

    // 1011 overlapping Mealy detector: match when the last three bits plus
    // the current det_x spell 1011. A cleared history of 000 cannot match.
    logic [2:0] hist;
    always_ff @(posedge clk) begin
        if (det_reset) hist <= 3'b000;
        else           hist <= {hist[1:0], det_x};
    end
    assign det_y = ({hist, det_x} == 4'b1011);

    // ---------------- scoreboard ----------------
    int pass_cnt = 0;
    int total    = 0;
    int fail_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: slide a 4-bit window over the MSB-first bit stream.
    logic       exp_hit;
    logic [4:0] exp_cnt, exp_fp;

    task automatic model(input logic [15:0] w);
        int c = 0;
        int f = -1;
        for (int i = 3; i < 16; i++) begin
            // bits at stream indices i-3..i are w[18-i] down to w[15-i]
            if (w[18-i -: 4] == 4'b1011) begin
                c++;
                if (f < 0) f = i;
            end
        end
        exp_hit = (c > 0);
        exp_cnt = (c > 31) ? 5'd31 : 5'(c);
        exp_fp  = (f < 0) ? 5'd0 : 5'(f);
    endtask

    // ---------------- driver tasks ----------------
    // Drive start for one edge; return in the CLEAR cycle.
    task automatic start_scan(input logic [15:0] w);
        data_in = w;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("clear_det_reset", det_reset, 1);
        check("clear_busy", busy, 1);
        check("clear_det_x", det_x, 0);
        check("clear_count_zero", match_count, 0);
        check("clear_hit_zero", hit, 0);
    endtask

    // From the CLEAR cycle: 16 SHIFT cycles then DONE (17 edges after the
    // accepting edge). start is held high for the first 'hold' SHIFT cycles.
    task automatic finish_scan(input logic [15:0] w, input int hold, input string tag);
        for (int i = 0; i < 16; i++) begin
            start = (i < hold);
            if (i < hold) data_in = 16'hFFFF;
            @(posedge clk); #1;
            check({tag, "_det_x"}, det_x, w[15-i]);
            check({tag, "_det_reset_low"}, det_reset, 0);
            check({tag, "_busy"}, busy, 1);
        end
        start = 1'b0;
        @(posedge clk); #1;
        model(w);
        check({tag, "_done"}, done, 1);
        check({tag, "_hit"}, hit, exp_hit);
        check({tag, "_count"}, match_count, exp_cnt);
        check({tag, "_first_pos"}, first_pos, exp_fp);
    endtask

    // One cycle after DONE: back in IDLE with results held.
    task automatic check_idle(input string tag);
        @(posedge clk); #1;
        check({tag, "_done_pulse_end"}, done, 0);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_hold_count"}, match_count, exp_cnt);
        check({tag, "_idle_hold_fp"}, first_pos, exp_fp);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [15:0] w;
        reset   = 1'b1;
        start   = 1'b0;
        start2  = 1'b0;
        data_in = 16'h0000;
        data2   = 4'h0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_det_x", det_x, 0);
        check("rst_det_reset", det_reset, 1);
        check("rst_hit", hit, 0);
        check("rst_count", match_count, 0);
        check("rst_fp", first_pos, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1 check("post_rst_det_reset", det_reset, 0);

        // Reference pattern with two overlapping matches
        start_scan(16'hB600);
        finish_scan(16'hB600, 0, "b600");
        check("b600_known_count", match_count, 2);
        check("b600_known_fp", first_pos, 3);
        check_idle("b600");

        // No matches at all
        start_scan(16'h0000);
        finish_scan(16'h0000, 0, "zero");
        check_idle("zero");

        // start held during SHIFT with a different data word: ignored
        start_scan(16'hB600);
        finish_scan(16'hB600, 10, "hold");
        check("hold_count", match_count, 2);
        check_idle("hold");

        // Reset in the 5th SHIFT cycle (bit index 4), after the first match
        start_scan(16'hB600);
        repeat (5) @(posedge clk);
        #1;
        check("mid_pre_hit", hit, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_hit", hit, 0);
        check("mid_rst_count", match_count, 0);
        check("mid_rst_fp", first_pos, 0);
        check("mid_rst_det_x", det_x, 0);
        check("mid_rst_det_reset", det_reset, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("after_rst_idle", busy, 0);
        start_scan(16'hB000);
        finish_scan(16'hB000, 0, "b000");
        check("b000_count", match_count, 1);
        check("b000_fp", first_pos, 3);

        // Back-to-back: start raised in the DONE cycle is ignored, the one
        // in the first IDLE cycle is accepted and clears the count.
        data_in = 16'h5B2D;
        start   = 1'b1;
        @(posedge clk); #1;
        check("b2b_done_start_ignored", busy, 0);
        check("b2b_hold_count", match_count, 1);
        start_scan(16'h5B2D);
        finish_scan(16'h5B2D, 0, "b2b");
        check_idle("b2b");

        // Randomized words with random idle gaps
        for (int r = 0; r < 8; r++) begin
            w = 16'($urandom);
            if (r == 0) w = 16'hB6DB;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            start_scan(w);
            finish_scan(w, int'($urandom_range(0, 6)), "rand");
            check_idle("rand");
        end

        // Saturating instance: 4 match cycles into a 2-bit count
        data2  = 4'($urandom);
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        check("sat_det_reset", det_reset2, 1);
        repeat (5) @(posedge clk);
        #1;
        check("sat_done", done2, 1);
        check("sat_count", mc2, 3);
        check("sat_fp", fp2, 0);
        check("sat_hit", hit2, 1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
